if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have ports imem_req output 1, imem_addr output 32, imem_gnt input 1, the fetch request channel; a request is accepted at an edge where imem_req=1 and imem_gnt=1.
REQ-005 SHALL have ports imem_rvalid input 1 and imem_rdata input 32, the fetch response; exactly one response per accepted request, arriving at least 1 cycle after acceptance.
REQ-006 SHALL have ports stall input 1 and flush input 1, both from the downstream pipeline.
REQ-007 SHALL have ports redirect_valid input 1 and redirect_pc input 32, the branch/jump target.
REQ-008 SHALL have ports id_valid output 1, id_pc output 32, id_instr output 32, the registered ID slot.
REQ-009 SHALL have ports id_imm_bits output 25 (id_instr[31:7]) and id_imm_src output 2, which feed the immediate extender.
REQ-010 SHALL have port id_illegal output 1, the decode-error flag.

Function
REQ-011 SHALL implement a 3-state FSM: REQ, WAIT and DROP, plus an additional state HOLD; at most one request is outstanding.
REQ-012 In REQ: imem_req=1 and imem_addr=pc, except imem_req=0 in any cycle with redirect_valid=1; on acceptance go to WAIT.
REQ-013 In WAIT with imem_rvalid=1 and no redirect:
- if the ID slot can load (!(id_valid && stall)): id_valid<=1, id_pc<=pc, id_instr<=imem_rdata; pc<=pc+4; go to REQ.
- otherwise: latch pc and data into a 1-entry skid buffer; pc<=pc+4; go to HOLD.
REQ-014 In HOLD: imem_req=0; when stall=0, the ID slot loads from the skid buffer; go to REQ.
REQ-015 redirect_valid=1 SHALL:
- set pc<=redirect_pc with bits [1:0] forced to 00;
- clear id_valid and the skid buffer at that edge.
Next state: from REQ or HOLD go to REQ; from WAIT go to DROP, or to REQ if imem_rvalid=1 in the same cycle (that response is discarded).
REQ-016 In DROP: imem_req=0; the next response is discarded; go to REQ. A further redirect in DROP only updates pc.
REQ-017 flush=1 with redirect_valid=0 SHALL clear id_valid and the skid buffer at the edge without changing pc or FSM state, except HOLD goes to REQ; a response arriving in the same WAIT cycle still loads normally.
REQ-018 When id_valid=1 and stall=1, all id_* outputs SHALL hold; flush and redirect override stall.
REQ-019 pc increments SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-020 id_imm_src SHALL be combinational from id_instr[6:0]:
- 0010011, 0000011, 1100111 -> 00
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- all others -> 00
REQ-021 id_illegal SHALL be 1 when id_valid=1 and either id_instr[1:0]!=11 or the opcode is outside the listed set plus 0110011, 0110111 and 0010111.
REQ-022 id_imm_bits and id_imm_src SHALL be valid only while id_valid=1.

Reset
REQ-023 While rst_n=0 the block SHALL hold: pc=RESET_PC, state=REQ, imem_req=0, id_valid=0, id_pc=0, id_instr=0, skid buffer empty.
REQ-024 imem_req SHALL first assert in the first cycle after rst_n deasserts.
REQ-025 Reset asserted mid-transaction SHALL abandon the outstanding request; no response is expected after reset.

Verification
REQ-026 Reset release, gnt=1, rvalid 1 cycle later with 32'h00A00093 -> addr 0 issued, id_valid=1, id_pc=0, id_imm_src=00, id_imm_bits=instr[31:7], id_illegal=0; next addr=4.
REQ-027 id_valid=1 and stall=1 while the response 32'h00112623 arrives -> FSM enters HOLD, imem_req=0, ID holds; when stall drops -> id_instr=32'h00112623, id_imm_src=01.
REQ-028 Redirect to 32'h0000_0103 while in WAIT -> next response discarded, next imem_addr=32'h0000_0100, id_valid=0 until the new response.
REQ-029 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-030 Instruction 32'h0000006F -> id_imm_src=11; instruction 32'h00000063 -> 10; instruction 32'h0000007F -> id_illegal=1; instruction 32'h00000010 -> id_illegal=1.
REQ-031 rst_n low during WAIT -> outputs reach reset values immediately (asynchronous); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : Instruction fetch with one outstanding request, registered ID
//               slot with a one-entry skid buffer, and immediate-type decode.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [24:0] id_imm_bits,
    output logic [1:0]  id_imm_src,
    output logic        id_illegal
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        w_can_load;
    logic        w_accept_resp;
    logic        w_skid_drain;
    logic        w_known_op;
    logic [6:0]  w_opcode;

    // Flush empties the slot in the same edge, so it frees the slot like !stall.
    assign w_can_load    = !(r_id_valid && stall) || flush;
    assign w_accept_resp = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_skid_drain  = (r_state == S_HOLD) && !stall && !flush && !redirect_valid;

    // rst_n gating keeps the request low while reset is held.
    assign imem_req  = rst_n && (r_state == S_REQ) && !redirect_valid;
    assign imem_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (imem_req && imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_state_nxt = w_can_load ? S_REQ : S_HOLD;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid || flush || !stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_id_valid   <= 1'b0;
            r_id_pc      <= 32'h0;
            r_id_instr   <= 32'h0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0;
            r_skid_instr <= 32'h0;
        end else if (redirect_valid) begin
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_id_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_accept_resp) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_accept_resp && w_can_load) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_pc;
                r_id_instr <= imem_rdata;
            end else if (w_skid_drain) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_skid_pc;
                r_id_instr <= r_skid_instr;
            end else if (flush || !stall) begin
                r_id_valid <= 1'b0;
            end

            if (w_accept_resp && !w_can_load) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem_rdata;
            end else if (flush || w_skid_drain) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_instr    = r_id_instr;
    assign id_imm_bits = r_id_instr[31:7];
    assign w_opcode    = r_id_instr[6:0];

    always_comb begin
        id_imm_src = 2'b00;
        case (w_opcode)
            c_OP_STORE: id_imm_src = 2'b01;
            c_OP_BR:    id_imm_src = 2'b10;
            c_OP_JAL:   id_imm_src = 2'b11;
            default:    id_imm_src = 2'b00;
        endcase
    end

    always_comb begin
        w_known_op = 1'b0;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_STORE, c_OP_BR,
            c_OP_JAL, c_OP_REG, c_OP_LUI, c_OP_AUIPC: w_known_op = 1'b1;
            default:                                  w_known_op = 1'b0;
        endcase
    end

    assign id_illegal = r_id_valid && ((r_id_instr[1:0] != 2'b11) || !w_known_op);

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Directed self-checking bench for if_id_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    logic        r_clk = 1'b0;
    logic        r_rst_n;
    logic        r_gnt;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_stall;
    logic        r_flush;
    logic        r_redir;
    logic [31:0] r_redir_pc;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_instr;
    logic [24:0] w_imm_bits;
    logic [1:0]  w_imm_src;
    logic        w_illegal;

    int checks = 0;
    int errors = 0;

    always #5 r_clk = ~r_clk;

    if_id_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (r_clk),
        .rst_n          (r_rst_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_gnt       (r_gnt),
        .imem_rvalid    (r_rvalid),
        .imem_rdata     (r_rdata),
        .stall          (r_stall),
        .flush          (r_flush),
        .redirect_valid (r_redir),
        .redirect_pc    (r_redir_pc),
        .id_valid       (w_id_valid),
        .id_pc          (w_id_pc),
        .id_instr       (w_id_instr),
        .id_imm_bits    (w_imm_bits),
        .id_imm_src     (w_imm_src),
        .id_illegal     (w_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge r_clk);
        #2;
    endtask

    // Grant in REQ, then respond one cycle later with stall low.
    task automatic fetch(input logic [31:0] instr);
        r_gnt = 1'b1;
        tick();
        r_gnt    = 1'b0;
        r_rvalid = 1'b1;
        r_rdata  = instr;
        tick();
        r_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        r_rst_n    = 1'b0;
        r_gnt      = 1'b0;
        r_rvalid   = 1'b0;
        r_rdata    = 32'h0;
        r_stall    = 1'b0;
        r_flush    = 1'b0;
        r_redir    = 1'b0;
        r_redir_pc = 32'h0;
        #3;
        check_eq("rst_req",      32'(w_req),      32'h0);
        check_eq("rst_id_valid", 32'(w_id_valid), 32'h0);
        check_eq("rst_id_pc",    w_id_pc,         32'h0);
        check_eq("rst_id_instr", w_id_instr,      32'h0);
        check_eq("rst_addr",     w_addr,          32'h0);
        tick();
        tick();

        // Basic fetch of addi x1,x0,10
        r_rst_n = 1'b1;
        #1;
        check_eq("first_req",  32'(w_req), 32'h1);
        check_eq("first_addr", w_addr,     32'h0);
        r_gnt = 1'b1;
        tick();
        r_gnt    = 1'b0;
        r_rvalid = 1'b1;
        r_rdata  = 32'h00A00093;
        #1;
        check_eq("wait_req", 32'(w_req), 32'h0);
        tick();
        r_rvalid = 1'b0;
        r_stall  = 1'b1;
        #1;
        check_eq("f0_valid",   32'(w_id_valid), 32'h1);
        check_eq("f0_pc",      w_id_pc,         32'h0);
        check_eq("f0_instr",   w_id_instr,      32'h00A00093);
        check_eq("f0_imm_src", 32'(w_imm_src),  32'h0);
        check_eq("f0_imm_bits",32'(w_imm_bits), 32'h0001_4001);
        check_eq("f0_illegal", 32'(w_illegal),  32'h0);
        check_eq("f0_next",    w_addr,          32'h4);
        check_eq("f0_nreq",    32'(w_req),      32'h1);

        // Response arrives while ID is stalled -> skid buffer / HOLD
        r_gnt = 1'b1;
        tick();
        r_gnt    = 1'b0;
        r_rvalid = 1'b1;
        r_rdata  = 32'h00112623;
        tick();
        r_rvalid = 1'b0;
        #1;
        check_eq("hold_req",   32'(w_req),      32'h0);
        check_eq("hold_valid", 32'(w_id_valid), 32'h1);
        check_eq("hold_instr", w_id_instr,      32'h00A00093);
        tick();
        #1;
        check_eq("hold2_req",   32'(w_req),  32'h0);
        check_eq("hold2_pc",    w_id_pc,     32'h0);
        r_stall = 1'b0;
        tick();
        #1;
        check_eq("skid_instr",   w_id_instr,      32'h00112623);
        check_eq("skid_pc",      w_id_pc,         32'h4);
        check_eq("skid_imm_src", 32'(w_imm_src),  32'h1);
        check_eq("skid_addr",    w_addr,          32'h8);
        check_eq("skid_req",     32'(w_req),      32'h1);

        // Redirect while in WAIT
        r_gnt = 1'b1;
        tick();
        r_gnt      = 1'b0;
        r_redir    = 1'b1;
        r_redir_pc = 32'h0000_0103;
        tick();
        r_redir = 1'b0;
        #1;
        check_eq("drop_valid", 32'(w_id_valid), 32'h0);
        check_eq("drop_req",   32'(w_req),      32'h0);
        check_eq("drop_addr",  w_addr,          32'h0000_0100);
        r_rvalid = 1'b1;
        r_rdata  = 32'h0000_0013;
        tick();
        r_rvalid = 1'b0;
        #1;
        check_eq("drop_disc", 32'(w_id_valid), 32'h0);
        check_eq("drop_rreq", 32'(w_req),      32'h1);
        check_eq("drop_raddr",w_addr,          32'h0000_0100);

        // Redirect in REQ suppresses the request, then wrap at the top of memory
        r_redir    = 1'b1;
        r_redir_pc = 32'hFFFF_FFFE;
        r_gnt      = 1'b1;
        #1;
        check_eq("redir_noreq", 32'(w_req), 32'h0);
        tick();
        r_redir = 1'b0;
        r_gnt   = 1'b0;
        #1;
        check_eq("top_addr", w_addr, 32'hFFFF_FFFC);
        fetch(32'h0000006F);
        check_eq("jal_pc",      w_id_pc,        32'hFFFF_FFFC);
        check_eq("jal_imm_src", 32'(w_imm_src), 32'h3);
        check_eq("jal_illegal", 32'(w_illegal), 32'h0);
        check_eq("wrap_addr",   w_addr,         32'h0);

        fetch(32'h00000063);
        check_eq("br_imm_src", 32'(w_imm_src), 32'h2);
        fetch(32'h0000007F);
        check_eq("bad_op_illegal", 32'(w_illegal), 32'h1);
        fetch(32'h00000010);
        check_eq("bad_lsb_illegal", 32'(w_illegal), 32'h1);
        check_eq("pre_flush_addr",  w_addr,          32'hC);

        // Flush in REQ clears ID but keeps pc
        r_flush = 1'b1;
        tick();
        r_flush = 1'b0;
        #1;
        check_eq("flush_valid",   32'(w_id_valid), 32'h0);
        check_eq("flush_illegal", 32'(w_illegal),  32'h0);
        check_eq("flush_addr",    w_addr,          32'hC);

        // Flush coincident with a response still loads it
        r_gnt = 1'b1;
        tick();
        r_gnt    = 1'b0;
        r_flush  = 1'b1;
        r_rvalid = 1'b1;
        r_rdata  = 32'h00000033;
        tick();
        r_flush  = 1'b0;
        r_rvalid = 1'b0;
        #1;
        check_eq("fl_resp_valid", 32'(w_id_valid), 32'h1);
        check_eq("fl_resp_instr", w_id_instr,      32'h00000033);
        check_eq("fl_resp_addr",  w_addr,          32'h10);

        // Asynchronous reset while waiting for a response
        r_gnt = 1'b1;
        tick();
        r_gnt = 1'b0;
        #1;
        r_rst_n = 1'b0;
        #1;
        check_eq("arst_req",   32'(w_req),      32'h0);
        check_eq("arst_valid", 32'(w_id_valid), 32'h0);
        check_eq("arst_instr", w_id_instr,      32'h0);
        check_eq("arst_addr",  w_addr,          32'h0);
        tick();
        r_rst_n = 1'b1;
        #1;
        check_eq("restart_req",  32'(w_req), 32'h1);
        check_eq("restart_addr", w_addr,     32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
